// File: rtl/arp.sv
// ARP engine on GMII: parses ARP request/reply frames addressed to this board,
// and builds complete ARP request/reply frames (preamble through FCS) on command.
module arp #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A,
  parameter logic [47:0] DES_MAC   = 48'h23_45_67_89_0A_BC,
  parameter logic [31:0] DES_IP    = 32'hC0_A8_01_17
) (
  input  logic        gmii_rx_clk,
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip,
  output logic        arp_tx_rdy
);

  // Expected bytes 0..59 after the SFD (plus 4 filler bytes so the index never
  // runs off the end). Destination MAC sits in bytes 0..5 for the unicast check.
  localparam logic [511:0] RX_EXP = {BOARD_MAC, 48'h0, 16'h0806, 16'h0001, 16'h0800,
                                     8'h06, 8'h04, 8'h00, 8'h00, 80'h0, 48'h0,
                                     BOARD_IP, 144'h0, 32'h0};
  // Bytes that must match RX_EXP exactly: 12..20 (type/htype/ptype/hlen/plen/oper hi)
  // and 38..41 (target IP). Bit 63-i covers byte i.
  localparam logic [63:0]  RX_CARE = {12'b0, 9'h1FF, 17'b0, 4'hF, 22'b0};

  // Reflected CRC-32 (0xEDB88320) over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // ---------------------------------------------------------------- RX path
  typedef enum logic [2:0] {
    RX_IDLE, RX_PREAMBLE, RX_ETH_HEAD, RX_ARP_DATA, RX_PAD, RX_FCS, RX_DONE, RX_WAIT_IDLE
  } rx_state_t;

  rx_state_t   rx_state, rx_nxt;
  logic [5:0]  rx_cnt;          // preamble count, then byte index after SFD
  logic [5:0]  rx_rev;
  logic [31:0] rx_crc, rx_crc_inv;
  logic [79:0] rx_snd;          // sender MAC + IP
  logic        rx_rep;          // OPER == 2
  logic        dst_me, dst_bc, dst_me_nxt, dst_bc_nxt;
  logic        rx_ok, rx_bad;
  logic [7:0]  rx_exp, rx_fcs;

  assign rx_rev     = 6'd63 - rx_cnt;
  assign rx_crc_inv = ~rx_crc;

  // RX next state: field checks on the byte being sampled this cycle
  always_comb begin
    rx_nxt     = rx_state;
    rx_ok      = 1'b0;
    rx_bad     = 1'b0;
    dst_me_nxt = dst_me;
    dst_bc_nxt = dst_bc;
    rx_exp     = RX_EXP[{rx_rev, 3'b000} +: 8];
    rx_fcs     = rx_crc_inv[{rx_cnt[1:0], 3'b000} +: 8];
    if (rx_cnt <= 6'd5) begin
      dst_me_nxt = dst_me & (gmii_rxd == rx_exp);
      dst_bc_nxt = dst_bc & (gmii_rxd == 8'hFF);
    end
    if (rx_cnt == 6'd5 && !(dst_me_nxt || dst_bc_nxt))              rx_bad = 1'b1;
    if (rx_cnt <= 6'd59 && RX_CARE[rx_rev] && gmii_rxd != rx_exp)   rx_bad = 1'b1;
    if (rx_cnt == 6'd21 && gmii_rxd != 8'h01 && gmii_rxd != 8'h02)  rx_bad = 1'b1;
    if (rx_cnt >= 6'd60 && gmii_rxd != rx_fcs)                      rx_bad = 1'b1;
    case (rx_state)
      RX_IDLE:
        if (gmii_rx_dv) rx_nxt = (gmii_rxd == 8'h55) ? RX_PREAMBLE : RX_WAIT_IDLE;
      RX_PREAMBLE:
        if (!gmii_rx_dv)                                 rx_nxt = RX_IDLE;
        else if (gmii_rxd == 8'h55 && rx_cnt < 6'd7)     rx_nxt = RX_PREAMBLE;
        else if (gmii_rxd == 8'hD5 && rx_cnt == 6'd7)    rx_nxt = RX_ETH_HEAD;
        else                                             rx_nxt = RX_WAIT_IDLE;
      RX_ETH_HEAD, RX_ARP_DATA, RX_PAD, RX_FCS:
        if (!gmii_rx_dv)          rx_nxt = RX_IDLE;
        else if (rx_bad)          rx_nxt = RX_WAIT_IDLE;
        else if (rx_cnt == 6'd63) begin rx_nxt = RX_DONE; rx_ok = 1'b1; end
        else if (rx_cnt >= 6'd59) rx_nxt = RX_FCS;
        else if (rx_cnt >= 6'd41) rx_nxt = RX_PAD;
        else if (rx_cnt >= 6'd13) rx_nxt = RX_ARP_DATA;
        else                      rx_nxt = RX_ETH_HEAD;
      RX_DONE:
        rx_nxt = gmii_rx_dv ? RX_WAIT_IDLE : RX_IDLE;
      RX_WAIT_IDLE:
        if (!gmii_rx_dv) rx_nxt = RX_IDLE;
      default: rx_nxt = RX_IDLE;
    endcase
  end

  // RX state, byte capture, CRC and result registers
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_crc      <= '1;
      rx_snd      <= '0;
      rx_rep      <= 1'b0;
      dst_me      <= 1'b1;
      dst_bc      <= 1'b1;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      rx_state    <= rx_nxt;
      arp_rx_done <= rx_ok;
      if (rx_ok) begin
        src_mac     <= rx_snd[79:32];
        src_ip      <= rx_snd[31:0];
        arp_rx_type <= rx_rep;
      end
      case (rx_state)
        RX_IDLE: rx_cnt <= 6'd1;
        RX_PREAMBLE:
          if (rx_nxt == RX_ETH_HEAD) begin
            rx_cnt <= '0;
            rx_crc <= '1;
            dst_me <= 1'b1;
            dst_bc <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 6'd1;
          end
        RX_ETH_HEAD, RX_ARP_DATA, RX_PAD, RX_FCS:
          if (gmii_rx_dv) begin
            rx_cnt <= rx_cnt + 6'd1;
            dst_me <= dst_me_nxt;
            dst_bc <= dst_bc_nxt;
            if (rx_cnt < 6'd60)                       rx_crc <= crc_byte(rx_crc, gmii_rxd);
            if (rx_cnt == 6'd21)                      rx_rep <= (gmii_rxd == 8'h02);
            if (rx_cnt >= 6'd22 && rx_cnt <= 6'd31)   rx_snd <= {rx_snd[71:0], gmii_rxd};
          end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX path
  typedef enum logic [2:0] {
    TX_IDLE, TX_PREAMBLE, TX_ETH_HEAD, TX_ARP_DATA, TX_PAD, TX_FCS
  } tx_state_t;

  tx_state_t    tx_state, tx_nxt;
  logic [6:0]   tx_cnt;         // index of the next byte to drive (0..71), 72 = end
  logic [479:0] tx_sh, tx_ld;   // dest MAC .. last pad byte, shifted out MSB first
  logic [31:0]  tx_crc, tx_crc_inv;
  logic [7:0]   tx_byte;
  logic [47:0]  tx_mac;
  logic [31:0]  tx_ip;

  assign tx_crc_inv = ~tx_crc;

  // Frame image built from the command inputs; loaded only on acceptance
  always_comb begin
    tx_mac = (des_mac == '0) ? DES_MAC : des_mac;
    tx_ip  = (des_ip  == '0) ? DES_IP  : des_ip;
    tx_ld  = {arp_tx_type ? tx_mac : 48'hFFFF_FFFF_FFFF, BOARD_MAC, 16'h0806,
              16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00,
              arp_tx_type ? 8'h02 : 8'h01, BOARD_MAC, BOARD_IP, tx_mac, tx_ip, 144'h0};
  end

  // TX next state and the byte selected for the wire
  always_comb begin
    tx_nxt = tx_state;
    if (tx_cnt < 7'd7)        tx_byte = 8'h55;
    else if (tx_cnt == 7'd7)  tx_byte = 8'hD5;
    else if (tx_cnt < 7'd68)  tx_byte = tx_sh[479:472];
    else                      tx_byte = tx_crc_inv[{tx_cnt[1:0], 3'b000} +: 8];
    case (tx_state)
      TX_IDLE: if (arp_tx_en) tx_nxt = TX_PREAMBLE;
      default:
        if (tx_cnt == 7'd72)     tx_nxt = TX_IDLE;
        else if (tx_cnt < 7'd8)  tx_nxt = TX_PREAMBLE;
        else if (tx_cnt < 7'd22) tx_nxt = TX_ETH_HEAD;
        else if (tx_cnt < 7'd50) tx_nxt = TX_ARP_DATA;
        else if (tx_cnt < 7'd68) tx_nxt = TX_PAD;
        else                     tx_nxt = TX_FCS;
    endcase
  end

  // TX state, shifter, CRC and registered GMII outputs
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_sh      <= '0;
      tx_crc     <= '1;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
      arp_tx_rdy <= 1'b1;
    end else begin
      tx_state <= tx_nxt;
      if (tx_state == TX_IDLE) begin
        if (arp_tx_en) begin
          tx_sh      <= tx_ld;
          tx_crc     <= '1;
          tx_cnt     <= 7'd1;
          gmii_tx_en <= 1'b1;
          gmii_txd   <= tx_byte;
          arp_tx_rdy <= 1'b0;
        end
      end else if (tx_cnt == 7'd72) begin
        tx_cnt     <= '0;
        gmii_tx_en <= 1'b0;
        gmii_txd   <= '0;
        arp_tx_rdy <= 1'b1;
      end else begin
        tx_cnt     <= tx_cnt + 7'd1;
        gmii_tx_en <= 1'b1;
        gmii_txd   <= tx_byte;
        if (tx_cnt >= 7'd8 && tx_cnt < 7'd68) begin
          tx_sh  <= {tx_sh[471:0], 8'h00};
          tx_crc <= crc_byte(tx_crc, tx_byte);
        end
      end
    end
  end

endmodule

// File: tb/tb_arp.sv
// Directed bench for arp: loopback TX->RX, injected good/bad frames, handshake and reset.
module tb_arp;
  localparam logic [47:0] BMAC = 48'h0011_2233_4455;
  localparam logic [31:0] BIP  = 32'hC0A8_010A;
  localparam logic [47:0] BCST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OMAC = 48'h0A0B_0C0D_0E0F;
  localparam logic [31:0] OIP  = 32'hC0A8_0105;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        rst_n, arp_tx_en, arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        loop, inj_dv;
  logic [7:0]  inj_d;
  logic        gmii_rx_dv, gmii_tx_en, arp_rx_done, arp_rx_type, arp_tx_rdy;
  logic [7:0]  gmii_rxd, gmii_txd;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  assign gmii_rx_dv = loop ? gmii_tx_en : inj_dv;
  assign gmii_rxd   = loop ? gmii_txd   : inj_d;

  arp dut (
    .gmii_rx_clk(clk), .gmii_tx_clk(clk), .rst_n(rst_n),
    .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
    .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
    .des_mac(des_mac), .des_ip(des_ip),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
    .src_mac(src_mac), .src_ip(src_ip), .arp_tx_rdy(arp_tx_rdy)
  );

  int checks = 0;
  int errors = 0;

  // Wire monitor: collects every transmitted byte, frame starts and done pulses
  logic [7:0] txbuf [0:1023];
  int   txlen = 0, frames = 0, dones = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (gmii_tx_en) begin
      if (txlen < 1024) txbuf[txlen] = gmii_txd;
      txlen++;
    end
    if (gmii_tx_en && !prev_en) frames++;
    prev_en = gmii_tx_en;
    if (arp_rx_done) dones++;
  end

  logic [7:0] fr [0:71];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bitwise reflected CRC-32 step
  function automatic logic [31:0] crc32(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    return r;
  endfunction

  // Lay out a full 72-byte ARP frame in fr[]
  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] op,
                       input logic [47:0] smac, input logic [31:0] sip,
                       input logic [47:0] tmac, input logic [31:0] tip);
    logic [479:0] v;
    logic [31:0]  c;
    v = {dst, smac, et, 16'h0001, 16'h0800, 8'h06, 8'h04, op, smac, sip, tmac, tip, 144'h0};
    for (int i = 0; i < 7; i++) fr[i] = 8'h55;
    fr[7] = 8'hD5;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      fr[8+i] = v[479-8*i -: 8];
      c = crc32(c, fr[8+i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fr[68+k] = c[8*k +: 8];
  endtask

  task automatic cmp_frame(input string tag, input int start);
    for (int i = 0; i < 72; i++)
      chk($sformatf("%s_byte%0d", tag, i), {56'h0, txbuf[start+i]}, {56'h0, fr[i]});
  endtask

  task automatic start_tx(input logic typ, input logic [47:0] m, input logic [31:0] ip);
    @(negedge clk);
    arp_tx_type = typ; des_mac = m; des_ip = ip; arp_tx_en = 1'b1;
    @(negedge clk);
    arp_tx_en = 1'b0;
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (arp_tx_rdy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_rdy_back"}, {63'h0, arp_tx_rdy}, 64'h1);
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); inj_dv = 1'b1; inj_d = fr[i];
    end
    @(negedge clk); inj_dv = 1'b0; inj_d = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  int s, f, d;

  initial begin
    rst_n = 1'b0; arp_tx_en = 1'b0; arp_tx_type = 1'b0; des_mac = '0; des_ip = '0;
    loop = 1'b1; inj_dv = 1'b0; inj_d = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_en",   {63'h0, gmii_tx_en},  64'h0);
    chk("rst_txd",     {56'h0, gmii_txd},    64'h0);
    chk("rst_done",    {63'h0, arp_rx_done}, 64'h0);
    chk("rst_type",    {63'h0, arp_rx_type}, 64'h0);
    chk("rst_src_mac", {16'h0, src_mac},     64'h0);
    chk("rst_src_ip",  {32'h0, src_ip},      64'h0);
    chk("rst_rdy",     {63'h0, arp_tx_rdy},  64'h1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // loopback request to ourselves
    s = txlen; d = dones;
    start_tx(1'b0, BMAC, BIP);
    chk("t1_rdy_low", {63'h0, arp_tx_rdy}, 64'h0);
    chk("t1_tx_en",   {63'h0, gmii_tx_en}, 64'h1);
    chk("t1_first",   {56'h0, gmii_txd},   64'h55);
    wait_rdy("t1");
    chk("t1_len", 64'(txlen - s), 64'd72);
    build(BCST, 16'h0806, 16'h0001, BMAC, BIP, BMAC, BIP);
    chk("t1_byte8", {56'h0, txbuf[s+8]}, 64'hFF);
    cmp_frame("t1", s);
    repeat (4) @(negedge clk);
    chk("t1_dones",   64'(dones - d), 64'd1);
    chk("t1_type",    {63'h0, arp_rx_type}, 64'h0);
    chk("t1_src_mac", {16'h0, src_mac}, {16'h0, BMAC});
    chk("t1_src_ip",  {32'h0, src_ip},  {32'h0, BIP});

    // loopback reply using what was just learned
    s = txlen; d = dones;
    start_tx(1'b1, src_mac, src_ip);
    wait_rdy("t2");
    build(BMAC, 16'h0806, 16'h0002, BMAC, BIP, BMAC, BIP);
    chk("t2_oper_hi", {56'h0, txbuf[s+28]}, 64'h00);
    chk("t2_oper_lo", {56'h0, txbuf[s+29]}, 64'h02);
    chk("t2_dst0",    {56'h0, txbuf[s+8]},  64'h00);
    chk("t2_dst5",    {56'h0, txbuf[s+13]}, 64'h55);
    cmp_frame("t2", s);
    repeat (4) @(negedge clk);
    chk("t2_dones", 64'(dones - d), 64'd1);
    chk("t2_type",  {63'h0, arp_rx_type}, 64'h1);

    // zero destination falls back to defaults; target IP is not ours so RX ignores it
    s = txlen; d = dones;
    start_tx(1'b0, 48'h0, 32'h0);
    wait_rdy("t3");
    build(BCST, 16'h0806, 16'h0001, BMAC, BIP, 48'h2345_6789_0ABC, 32'hC0A8_0117);
    chk("t3_tip0",  {56'h0, txbuf[s+46]}, 64'hC0);
    chk("t3_tip1",  {56'h0, txbuf[s+47]}, 64'hA8);
    chk("t3_tip2",  {56'h0, txbuf[s+48]}, 64'h01);
    chk("t3_tip3",  {56'h0, txbuf[s+49]}, 64'h17);
    chk("t3_tmac0", {56'h0, txbuf[s+40]}, 64'h23);
    chk("t3_tmac5", {56'h0, txbuf[s+45]}, 64'hBC);
    cmp_frame("t3", s);
    repeat (4) @(negedge clk);
    chk("t3_dones", 64'(dones - d), 64'd0);
    chk("t3_type",  {63'h0, arp_rx_type}, 64'h1);

    // injected frames that must be rejected
    loop = 1'b0;
    d = dones;
    build(BMAC, 16'h0806, 16'h0001, OMAC, OIP, 48'h0, 32'hC0A8_0163);
    send(72);
    chk("bad_tip_dones", 64'(dones - d), 64'd0);
    chk("bad_tip_mac",   {16'h0, src_mac}, {16'h0, BMAC});
    build(BMAC, 16'h0806, 16'h0001, OMAC, OIP, 48'h0, BIP);
    fr[70] = fr[70] ^ 8'h01;
    send(72);
    chk("bad_fcs_dones", 64'(dones - d), 64'd0);
    chk("bad_fcs_ip",    {32'h0, src_ip}, {32'h0, BIP});
    build(BMAC, 16'h0800, 16'h0001, OMAC, OIP, 48'h0, BIP);
    send(72);
    chk("bad_et_dones", 64'(dones - d), 64'd0);
    chk("bad_et_mac",   {16'h0, src_mac}, {16'h0, BMAC});

    // truncated frame, then a complete one
    build(BMAC, 16'h0806, 16'h0001, OMAC, OIP, 48'h0, BIP);
    send(30);
    chk("trunc_dones", 64'(dones - d), 64'd0);
    send(72);
    chk("full_dones",   64'(dones - d), 64'd1);
    chk("full_src_mac", {16'h0, src_mac}, {16'h0, OMAC});
    chk("full_src_ip",  {32'h0, src_ip},  {32'h0, OIP});
    chk("full_type",    {63'h0, arp_rx_type}, 64'h0);

    // a second start pulse while busy is ignored
    loop = 1'b1;
    s = txlen; f = frames;
    start_tx(1'b0, BMAC, BIP);
    repeat (10) @(negedge clk);
    arp_tx_type = 1'b1; arp_tx_en = 1'b1;
    @(negedge clk);
    arp_tx_en = 1'b0;
    wait_rdy("t5");
    repeat (20) @(negedge clk);
    chk("busy_frames", 64'(frames - f), 64'd1);
    chk("busy_len",    64'(txlen - s),  64'd72);
    chk("busy_idle",   {63'h0, gmii_tx_en}, 64'h0);

    // asynchronous reset in the middle of a frame
    start_tx(1'b0, BMAC, BIP);
    repeat (20) @(negedge clk);
    chk("pre_rst_tx_en", {63'h0, gmii_tx_en}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_en", {63'h0, gmii_tx_en}, 64'h0);
    chk("arst_txd",   {56'h0, gmii_txd},   64'h0);
    chk("arst_rdy",   {63'h0, arp_tx_rdy}, 64'h1);
    chk("arst_src",   {16'h0, src_mac},    64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arp.md
Name: arp

Overview:
- ARP engine on a GMII interface (8-bit, 125 MHz).
- Receive path parses ARP request and reply frames addressed to this board. It reports the sender MAC and IP and the opcode.
- Transmit path builds complete ARP request or reply frames on command: preamble, SFD, header, payload, padding and FCS.
- Sits between the GMII PHY wrapper and the host or UDP control logic.

Parameters:
- BOARD_MAC, 48'h00_11_22_33_44_55, local MAC address.
- BOARD_IP, 32'hC0_A8_01_0A (192.168.1.10), local IPv4 address.
- DES_MAC, 48'h23_45_67_89_0A_BC, default destination MAC. Used when des_mac is all zero.
- DES_IP, 32'hC0_A8_01_17 (192.168.1.23), default destination IP. Used when des_ip is all zero.

Ports:
- gmii_rx_clk  in  1  clock for the receive path.
- gmii_tx_clk  in  1  clock for the transmit path. Must be driven by the same clock as gmii_rx_clk; the block is one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rxd  in  8  receive byte.
- arp_tx_en  in  1  one-cycle transmit start pulse.
- arp_tx_type  in  1  0 = request, 1 = reply.
- des_mac  in  48  target MAC for transmission.
- des_ip  in  32  target IP for transmission.
- gmii_tx_en  out  1  transmit enable.
- gmii_txd  out  8  transmit byte.
- arp_rx_done  out  1  one-cycle pulse when a valid ARP frame is received.
- arp_rx_type  out  1  0 = request received, 1 = reply received.
- src_mac  out  48  sender MAC of the last valid frame.
- src_ip  out  32  sender IP of the last valid frame.
- arp_tx_rdy  out  1  transmitter idle and able to accept arp_tx_en.

Behaviour:
Reset values:
- gmii_tx_en = 0, gmii_txd = 0.
- arp_rx_done = 0, arp_rx_type = 0.
- src_mac = 0, src_ip = 0.
- arp_tx_rdy = 1.

Frame layout (72 bytes, both paths), in byte order:
- 7 × 0x55 preamble, then 0xD5 SFD.
- Destination MAC (6 bytes), source MAC (6 bytes), EtherType 0x0806.
- HTYPE 0x0001, PTYPE 0x0800, HLEN 0x06, PLEN 0x04.
- OPER 0x0001 (request) or 0x0002 (reply).
- Sender MAC (6), sender IP (4), target MAC (6), target IP (4).
- 18 × 0x00 padding.
- 4-byte FCS.
- All multi-byte fields are sent MSB byte first.

FCS:
- Standard Ethernet CRC-32 (polynomial 0x04C11DB7, init 0xFFFFFFFF, reflected, final inversion).
- Covers destination MAC through the last padding byte (60 bytes).
- Sent in standard Ethernet order, so that a standard receiver accepts the frame.

RX state machine (states: IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, PAD, FCS, DONE, WAIT_IDLE):
- Bytes are sampled when gmii_rx_dv = 1. The preamble requires seven 0x55 bytes followed by 0xD5.
- Destination MAC must equal BOARD_MAC or FF:FF:FF:FF:FF:FF.
- EtherType must be 0x0806.
- HTYPE, PTYPE, HLEN and PLEN must match the fixed values above.
- OPER must be 1 or 2.
- Target IP must equal BOARD_IP.
- The received FCS must match the CRC computed over the frame.
- Any mismatch goes to WAIT_IDLE: no arp_rx_done, and the outputs keep their old values.
- gmii_rx_dv falling before the last FCS byte aborts the frame and returns to IDLE, with no arp_rx_done.
- On success, one cycle after the last FCS byte is sampled:
  - arp_rx_done pulses for exactly 1 cycle.
  - In the same cycle, src_mac and src_ip take the sender fields and arp_rx_type = (OPER == 2).
  - src_mac, src_ip and arp_rx_type then hold until the next valid frame.
- Bytes after the FCS are ignored until gmii_rx_dv goes low. A new frame is recognised only after gmii_rx_dv has been low for at least 1 cycle.

TX state machine (states: IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, PAD, FCS):
Start handshake:
- arp_tx_en is sampled on a clock edge while arp_tx_rdy = 1.
- At that edge, arp_tx_type, des_mac and des_ip are latched. An all-zero des_mac or des_ip is replaced by DES_MAC or DES_IP respectively.
- arp_tx_rdy goes low on the next cycle.
- arp_tx_en is ignored while arp_tx_rdy = 0.

Frame output:
- gmii_tx_en rises 1 cycle after acceptance, carrying the first 0x55.
- gmii_tx_en stays high for exactly 72 consecutive cycles.
- Request: Ethernet destination = FF:FF:FF:FF:FF:FF, target MAC = latched MAC.
- Reply: Ethernet destination = latched MAC, target MAC = latched MAC.
- In both cases: source MAC = sender MAC = BOARD_MAC, sender IP = BOARD_IP, target IP = latched IP.

End of frame:
- In the cycle after the last FCS byte, gmii_tx_en = 0 and gmii_txd = 0.
- arp_tx_rdy returns to 1 in the same cycle.
- arp_tx_en held high at that edge starts a new frame with no idle gap.

Reset mid-frame:
- Both paths return to IDLE immediately.
- All outputs return to their reset values.

Test Plan:
- Loopback gmii_txd/gmii_tx_en into gmii_rxd/gmii_rx_dv. Apply reset, then pulse arp_tx_en with arp_tx_type = 0, des_mac = BOARD_MAC, des_ip = BOARD_IP. Expect:
  - arp_tx_rdy low, 72 cycles of gmii_tx_en, first byte 0x55, byte 8 = 0xFF.
  - arp_rx_done single pulse, arp_rx_type = 0.
  - src_mac = 48'h001122334455, src_ip = C0A8010A.
  - arp_tx_rdy rises back to 1.
- Same loopback; after arp_tx_rdy rises, send a reply (arp_tx_type = 1) with des_mac = src_mac and des_ip = src_ip. Expect OPER bytes 00 02, Ethernet destination 00:11:22:33:44:55, arp_rx_done pulse with arp_rx_type = 1.
- Request with des_mac = 0 and des_ip = 0. Expect target IP bytes C0 A8 01 17 and target MAC 23:45:67:89:0A:BC on gmii_txd.
- Inject a frame with target IP 192.168.1.99, then one with a corrupted FCS byte, then one with EtherType 0x0800. Expect no arp_rx_done and src_mac/src_ip unchanged each time.
- Drop gmii_rx_dv after 30 bytes of a valid frame, then send a full valid frame. Expect no pulse for the first frame and exactly one pulse for the second.
- Pulse arp_tx_en again while arp_tx_rdy = 0. Expect it to be ignored: only one 72-byte frame is sent. Then assert rst_n = 0 mid-frame: gmii_tx_en drops to 0 asynchronously and arp_tx_rdy = 1.
